stg4ma: RTL and testbench



---
 rtl/stg4ma.sv | 145 ++++++++++++++
 tb/tb_stg4ma.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/stg4ma.sv
// stg4ma: memory-access stage between execute and write-back.
// ALU ops pass in one cycle; LD/ST hold upstream until data memory acks.
package stg4ma_pkg;
    localparam int SIZE_ADDR   = 24;
    localparam int SIZE_DATA   = 24;
    localparam int SIZE_OPC    = 5;
    localparam int SIZE_TGT_GP = 4;
    localparam int SIZE_TGT_SR = 2;

    localparam logic [SIZE_OPC-1:0] OPC_M_LD = 5'h10;
    localparam logic [SIZE_OPC-1:0] OPC_M_ST = 5'h11;
endpackage

module stg4ma
    import stg4ma_pkg::*;
#(
    parameter int ADDR_W = SIZE_ADDR,
    parameter int DATA_W = SIZE_DATA,
    parameter int OPC_W  = SIZE_OPC
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst_n,
    input  logic [ADDR_W-1:0]      iw_pc,
    input  logic [DATA_W-1:0]      iw_instr,
    input  logic [OPC_W-1:0]       iw_opc,
    input  logic [SIZE_TGT_GP-1:0] iw_tgt_gp,
    input  logic [SIZE_TGT_SR-1:0] iw_tgt_sr,
    input  logic [DATA_W-1:0]      iw_result,
    input  logic [DATA_W-1:0]      iw_st_data,
    output logic                   ow_stall,
    output logic                   ow_mem_req,
    output logic                   ow_mem_we,
    output logic [ADDR_W-1:0]      ow_mem_addr,
    output logic [DATA_W-1:0]      ow_mem_wdata,
    input  logic                   iw_mem_ack,
    input  logic [DATA_W-1:0]      iw_mem_rdata,
    output logic [ADDR_W-1:0]      ow_pc,
    output logic [DATA_W-1:0]      ow_instr,
    output logic [OPC_W-1:0]       ow_opc,
    output logic [SIZE_TGT_GP-1:0] ow_tgt_gp,
    output logic [SIZE_TGT_SR-1:0] ow_tgt_sr,
    output logic [DATA_W-1:0]      ow_result
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [OPC_W-1:0] LD = OPC_W'(OPC_M_LD);
    localparam logic [OPC_W-1:0] ST = OPC_W'(OPC_M_ST);

    state_t                 state;
    logic [ADDR_W-1:0]      hold_pc;
    logic [DATA_W-1:0]      hold_instr;
    logic [OPC_W-1:0]       hold_opc;
    logic [SIZE_TGT_GP-1:0] hold_tgt_gp;
    logic [SIZE_TGT_SR-1:0] hold_tgt_sr;
    logic [ADDR_W-1:0]      hold_addr;
    logic [DATA_W-1:0]      hold_wdata;
    logic                   hold_we;
    logic                   is_mem;
    logic                   busy;

    assign is_mem = (iw_opc == LD) || (iw_opc == ST);
    assign busy   = (state == S_WAIT);

    // Hold registers keep stale values after ack, so gate the bus in IDLE.
    assign ow_stall     = busy;
    assign ow_mem_req   = busy;
    assign ow_mem_we    = busy & hold_we;
    assign ow_mem_addr  = busy ? hold_addr : '0;
    assign ow_mem_wdata = busy ? hold_wdata : '0;

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state       <= S_IDLE;
            hold_pc     <= '0;
            hold_instr  <= '0;
            hold_opc    <= '0;
            hold_tgt_gp <= '0;
            hold_tgt_sr <= '0;
            hold_addr   <= '0;
            hold_wdata  <= '0;
            hold_we     <= 1'b0;
            ow_pc       <= '0;
            ow_instr    <= '0;
            ow_opc      <= '0;
            ow_tgt_gp   <= '0;
            ow_tgt_sr   <= '0;
            ow_result   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (is_mem) begin
                        hold_pc     <= iw_pc;
                        hold_instr  <= iw_instr;
                        hold_opc    <= iw_opc;
                        hold_tgt_gp <= iw_tgt_gp;
                        hold_tgt_sr <= iw_tgt_sr;
                        hold_addr   <= iw_result[ADDR_W-1:0];
                        hold_wdata  <= iw_st_data;
                        hold_we     <= (iw_opc == ST);
                        ow_pc       <= '0;
                        ow_instr    <= '0;
                        ow_opc      <= '0;
                        ow_tgt_gp   <= '0;
                        ow_tgt_sr   <= '0;
                        ow_result   <= '0;
                        state       <= S_WAIT;
                    end else begin
                        ow_pc     <= iw_pc;
                        ow_instr  <= iw_instr;
                        ow_opc    <= iw_opc;
                        ow_tgt_gp <= iw_tgt_gp;
                        ow_tgt_sr <= iw_tgt_sr;
                        ow_result <= iw_result;
                    end
                end
                S_WAIT: begin
                    if (iw_mem_ack) begin
                        ow_pc     <= hold_pc;
                        ow_instr  <= hold_instr;
                        ow_opc    <= hold_opc;
                        ow_tgt_gp <= hold_tgt_gp;
                        ow_tgt_sr <= hold_tgt_sr;
                        // Stores report their address back to write-back.
                        ow_result <= hold_we ? DATA_W'(hold_addr)
                                             : iw_mem_rdata;
                        state     <= S_IDLE;
                    end else begin
                        ow_pc     <= '0;
                        ow_instr  <= '0;
                        ow_opc    <= '0;
                        ow_tgt_gp <= '0;
                        ow_tgt_sr <= '0;
                        ow_result <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stg4ma.sv
// Directed bench for stg4ma with an in-order scoreboard on the
// write-back outputs plus per-cycle checks of the memory handshake.
module tb_stg4ma;
    import stg4ma_pkg::*;

    localparam logic [4:0] ADD = 5'h01;
    localparam logic [4:0] XOR = 5'h02;
    localparam logic [4:0] LD  = OPC_M_LD;
    localparam logic [4:0] ST  = OPC_M_ST;

    typedef struct packed {
        logic [23:0] pc;
        logic [23:0] instr;
        logic [4:0]  opc;
        logic [3:0]  gp;
        logic [1:0]  sr;
        logic [23:0] result;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] pc, instr, result, st_data, mem_rdata;
    logic [4:0]  opc;
    logic [3:0]  tgt_gp;
    logic [1:0]  tgt_sr;
    logic        mem_ack;
    logic        stall, mem_req, mem_we;
    logic [23:0] mem_addr, mem_wdata;
    logic [23:0] wb_pc, wb_instr, wb_result;
    logic [4:0]  wb_opc;
    logic [3:0]  wb_gp;
    logic [1:0]  wb_sr;

    int   checks = 0;
    int   failures = 0;
    rec_t sb[$];

    always #5 clk = ~clk;

    stg4ma dut (
        .iw_clk(clk), .iw_rst_n(rst_n),
        .iw_pc(pc), .iw_instr(instr), .iw_opc(opc),
        .iw_tgt_gp(tgt_gp), .iw_tgt_sr(tgt_sr),
        .iw_result(result), .iw_st_data(st_data),
        .ow_stall(stall), .ow_mem_req(mem_req), .ow_mem_we(mem_we),
        .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata),
        .iw_mem_ack(mem_ack), .iw_mem_rdata(mem_rdata),
        .ow_pc(wb_pc), .ow_instr(wb_instr), .ow_opc(wb_opc),
        .ow_tgt_gp(wb_gp), .ow_tgt_sr(wb_sr), .ow_result(wb_result)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] o, input logic [23:0] p,
                          input logic [3:0] g, input logic [23:0] r,
                          input logic [23:0] sd);
        opc = o; pc = p; instr = {5'h0, o, p[13:0]};
        tgt_gp = g; tgt_sr = p[1:0]; result = r; st_data = sd;
    endtask

    task automatic expect_out(input logic [23:0] r);
        rec_t e;
        e.pc = pc; e.instr = instr; e.opc = opc;
        e.gp = tgt_gp; e.sr = tgt_sr; e.result = r;
        sb.push_back(e);
    endtask

    // Every non-bubble write-back must match the oldest pending entry.
    always @(negedge clk) begin
        rec_t got, e;
        if (rst_n === 1'b1 && wb_opc !== 5'h0) begin
            got = {wb_pc, wb_instr, wb_opc, wb_gp, wb_sr, wb_result};
            if (sb.size() == 0) begin
                check("sb_underflow", 128'(sb.size()), 128'd1);
            end else begin
                e = sb.pop_front();
                check("sb_out", 128'(got), 128'(e));
            end
        end
    end

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        set_in(5'h0, 24'h0, 4'h0, 24'h0, 24'h0);
        #12;
        check("rst_outs", {wb_pc, wb_instr, wb_opc, wb_result}, '0);
        check("rst_bus", {stall, mem_req, mem_we, mem_addr, mem_wdata}, '0);
        @(negedge clk); rst_n = 1'b1;

        // Pass-through stream
        @(negedge clk);
        set_in(ADD, 24'h000010, 4'd3, 24'h000123, 24'h0); expect_out(result);
        @(negedge clk);
        check("add_res", wb_result, 24'h000123);
        check("add_stall", stall, 1'b0);
        set_in(XOR, 24'h000014, 4'd4, 24'hFFFFFF, 24'h0); expect_out(result);
        @(negedge clk);
        check("xor_res", wb_result, 24'hFFFFFF);
        check("xor_stall", stall, 1'b0);
        set_in(5'h0, 24'h0, 4'h0, 24'h0, 24'h0);

        // Load, ack on the third WAIT cycle
        @(negedge clk);
        set_in(LD, 24'h000020, 4'd5, 24'h000040, 24'h0);
        expect_out(24'hABCDEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ld_req", {mem_req, mem_we, mem_addr}, {2'b10, 24'h000040});
            check("ld_stall", stall, 1'b1);
            check("ld_bubble", {wb_opc, wb_result}, '0);
            if (i == 2) begin
                mem_ack = 1'b1; mem_rdata = 24'hABCDEF;
            end
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        check("ld_res", {wb_result, wb_gp}, {24'hABCDEF, 4'd5});
        check("ld_done", {stall, mem_req}, 2'b00);

        // Store, ack on the first WAIT cycle
        set_in(ST, 24'h000024, 4'd6, 24'h000100, 24'h00BEEF);
        expect_out(24'h000100);
        @(negedge clk);
        check("st_bus", {mem_req, mem_we, mem_addr, mem_wdata},
              {2'b11, 24'h000100, 24'h00BEEF});
        mem_ack = 1'b1;
        set_in(5'h0, 24'h0, 4'h0, 24'h0, 24'h0);
        @(negedge clk);
        mem_ack = 1'b0;
        check("st_res", {wb_opc, wb_result}, {ST, 24'h000100});
        check("st_idle", {mem_req, mem_we, mem_addr, mem_wdata}, '0);

        // Back-to-back LD, LD, ADD
        set_in(LD, 24'h000030, 4'd7, 24'h000200, 24'h0);
        expect_out(24'h111111);
        @(negedge clk);
        check("b2b_req0", mem_req, 1'b1);
        set_in(LD, 24'h000034, 4'd8, 24'h000204, 24'h0);
        expect_out(24'h222222);
        mem_ack = 1'b1; mem_rdata = 24'h111111;
        @(negedge clk);
        check("b2b_req1", mem_req, 1'b0);
        check("b2b_ld1", wb_result, 24'h111111);
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        check("b2b_req2", {mem_req, mem_addr}, {1'b1, 24'h000204});
        set_in(ADD, 24'h000038, 4'd9, 24'h000777, 24'h0);
        expect_out(24'h000777);
        mem_ack = 1'b1; mem_rdata = 24'h222222;
        @(negedge clk);
        check("b2b_ld2", wb_result, 24'h222222);
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        check("b2b_add", {wb_opc, wb_result}, {ADD, 24'h000777});
        check("b2b_stall", stall, 1'b0);

        // Spurious ack in IDLE during an ALU stream
        mem_ack = 1'b1; mem_rdata = 24'h5A5A5A;
        for (int i = 0; i < 3; i++) begin
            set_in(XOR, 24'h000040 + 24'(i), 4'(i), 24'h000300 + 24'(i),
                   24'h0);
            expect_out(result);
            @(negedge clk);
            check("spur_res", wb_result, 24'h000300 + 24'(i));
            check("spur_bus", {stall, mem_req}, 2'b00);
        end
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset while a load is waiting
        set_in(LD, 24'h000050, 4'd2, 24'h000400, 24'h0);
        @(negedge clk);
        check("rw_req", {mem_req, stall}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("rw_bus", {stall, mem_req, mem_we, mem_addr, mem_wdata}, '0);
        check("rw_outs", {wb_pc, wb_instr, wb_opc, wb_result}, '0);
        set_in(5'h0, 24'h0, 4'h0, 24'h0, 24'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("rw_idle", {stall, mem_req}, 2'b00);
        set_in(ADD, 24'h000060, 4'd1, 24'h000ABC, 24'h0); expect_out(result);
        @(negedge clk);
        check("rw_pass", {wb_opc, wb_result}, {ADD, 24'h000ABC});
        set_in(5'h0, 24'h0, 4'h0, 24'h0, 24'h0);
        @(negedge clk);
        check("sb_empty", 128'(sb.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
